// File: rtl/operand_sel_pipe_pkg.sv
// ---------------------------------------------------------------------------
// decode_pkg
// Shared decode-stage definitions used by the operand selector and by the
// decoder that produces its select codes.
//   DEFAULT_WIDTH / DEFAULT_N_IN : default operand width and candidate count
//   opsel_e                      : operand-select encodings from the decoder
//   operand_payload_t            : {data, err} beat carried through the pipe
// ---------------------------------------------------------------------------
package decode_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_N_IN  = 8;

  // Candidate slot order on the selector's in_data bus.
  typedef enum logic [2:0] {
    OPSEL_RS1     = 3'd0,
    OPSEL_RS2     = 3'd1,
    OPSEL_IMM     = 3'd2,
    OPSEL_PC      = 3'd3,
    OPSEL_ZERO    = 3'd4,
    OPSEL_FWD_EX  = 3'd5,
    OPSEL_FWD_MEM = 3'd6,
    OPSEL_FWD_WB  = 3'd7
  } opsel_e;

  // Beat layout at the default width; err sits in the least significant bit.
  typedef struct packed {
    logic [DEFAULT_WIDTH-1:0] data;
    logic                     err;
  } operand_payload_t;

endpackage

// File: rtl/operand_sel_pipe_skid_buf.sv
// ---------------------------------------------------------------------------
// skid_buf
// Generic two-entry valid/ready buffer: a main register that drives the
// output and a skid register that catches the one beat still in flight when
// the consumer stalls. in_ready comes straight from a flop.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   upstream handshake, in_data payload (PW bits)
//   out_valid/out_ready downstream handshake, out_data payload (PW bits)
// ---------------------------------------------------------------------------
module skid_buf #(
  parameter int PW = 65
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data
);

  logic          main_valid_q, main_valid_d;
  logic [PW-1:0] main_data_q, main_data_d;
  logic          skid_valid_q, skid_valid_d;
  logic [PW-1:0] skid_data_q, skid_data_d;
  logic          accept;
  logic          main_free;

  // Ready depends only on skid occupancy, so out_ready never reaches in_ready.
  assign in_ready  = !skid_valid_q;
  assign accept    = in_valid && !skid_valid_q;
  // Main can take a new beat if it is empty or its beat leaves this cycle.
  assign main_free = !main_valid_q || out_ready;

  // Next-state for both entries. The skid entry always refills main before
  // a new beat can, which keeps beats in acceptance order. A new beat can
  // never arrive while skid is full because in_ready is low then.
  always_comb begin
    main_valid_d = main_valid_q;
    main_data_d  = main_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (main_free) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_data_d  = skid_data_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_valid_d = 1'b1;
        main_data_d  = in_data;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = in_data;
    end
  end

  // State register; reset empties both entries and zeroes the output data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_q <= 1'b0;
      main_data_q  <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_data_q  <= main_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign out_valid = main_valid_q;
  assign out_data  = main_data_q;

endmodule

// File: rtl/operand_sel_pipe.sv
// ---------------------------------------------------------------------------
// operand_sel_pipe
// Registered N-way operand selector for the decode stage. Each accepted beat
// picks one of N_IN candidates by in_sel and is delivered one cycle later
// through a two-entry skid buffer. Out-of-range selects emit the last good
// operand with an error flag and bump a saturating error counter.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     upstream handshake
//   in_sel                select code (SEL_W bits)
//   in_data               N_IN candidates, operand k at [k*WIDTH +: WIDTH]
//   out_valid/out_ready   downstream handshake
//   out_data              selected operand
//   out_sel_err           beat's select code was out of range
//   err_count             saturating count of out-of-range beats accepted
//   err_clr               synchronous clear of err_count
// ---------------------------------------------------------------------------
module operand_sel_pipe
  import decode_pkg::*;
#(
  parameter int  WIDTH     = DEFAULT_WIDTH,
  parameter int  N_IN      = DEFAULT_N_IN,
  localparam int SEL_W     = $clog2(N_IN),
  parameter int  ERR_CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic [N_IN*WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_sel_err,
  output logic [ERR_CNT_W-1:0]  err_count,
  input  logic                  err_clr
);

  // One extra bit so the compare also works when N_IN is a power of two.
  localparam logic [SEL_W:0] NUM_INPUTS = (SEL_W + 1)'(N_IN);

  logic                 accept;
  logic                 sel_ok;
  logic [WIDTH-1:0]     sel_operand;
  logic [WIDTH:0]       beat_payload;
  logic [WIDTH:0]       out_payload;
  logic [WIDTH-1:0]     last_good_q, last_good_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  assign accept = in_valid && in_ready;
  assign sel_ok = {1'b0, in_sel} < NUM_INPUTS;

  // Compare-based mux so an out-of-range code never indexes past in_data.
  always_comb begin
    sel_operand = '0;
    for (int k = 0; k < N_IN; k++) begin
      if (in_sel == SEL_W'(k)) begin
        sel_operand = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // A bad select repeats the last good operand so the output stays defined.
  assign beat_payload = sel_ok ? {sel_operand, 1'b0} : {last_good_q, 1'b1};

  // last_good follows good accepted beats; the counter saturates at all-ones
  // and a clear overrides any increment in the same cycle.
  always_comb begin
    last_good_d = last_good_q;
    err_count_d = err_count_q;
    if (accept && sel_ok) begin
      last_good_d = sel_operand;
    end
    if (err_clr) begin
      err_count_d = '0;
    end else if (accept && !sel_ok && (err_count_q != '1)) begin
      err_count_d = err_count_q + 1'b1;
    end
  end

  // Selector state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_good_q <= '0;
      err_count_q <= '0;
    end else begin
      last_good_q <= last_good_d;
      err_count_q <= err_count_d;
    end
  end

  skid_buf #(
    .PW(WIDTH + 1)
  ) u_skid_buf (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (beat_payload),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_payload)
  );

  assign out_data    = out_payload[WIDTH:1];
  assign out_sel_err = out_payload[0];
  assign err_count   = err_count_q;

endmodule

// File: tb/tb_operand_sel_pipe.sv
// ---------------------------------------------------------------------------
// tb_operand_sel_pipe
// Directed bench for operand_sel_pipe. A 6-input, 2-bit-counter instance
// covers out-of-range selects, backpressure, saturation, reset and a long
// random valid/ready run; an 8-input instance covers plain streaming.
// ---------------------------------------------------------------------------
module tb_operand_sel_pipe;

  logic         clk;
  logic         rst_n;

  // 6-input instance
  logic         inValid;
  logic         inReady;
  logic [2:0]   inSel;
  logic [383:0] inData;
  logic         outValid;
  logic         outReady;
  logic [63:0]  outData;
  logic         outSelErr;
  logic [1:0]   errCount;
  logic         errClr;

  // 8-input instance
  logic         streamValid;
  logic         streamReady;
  logic [2:0]   streamSel;
  logic [511:0] streamData;
  logic         streamOutValid;
  logic         streamOutReady;
  logic [63:0]  streamOutData;
  logic         streamOutSelErr;
  logic [7:0]   streamErrCount;
  logic         streamErrClr;

  int           checkCount;
  int           failCount;

  logic [63:0]  cand [6];
  logic [64:0]  expQ [$];
  logic [64:0]  expBeat;
  logic [64:0]  prevPayload;
  logic         prevStalled;
  logic [63:0]  modelLast;
  logic [1:0]   modelErr;
  int           acceptCount;
  int           cycles;

  operand_sel_pipe #(
    .WIDTH    (64),
    .N_IN     (6),
    .ERR_CNT_W(2)
  ) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_sel     (inSel),
    .in_data    (inData),
    .out_valid  (outValid),
    .out_ready  (outReady),
    .out_data   (outData),
    .out_sel_err(outSelErr),
    .err_count  (errCount),
    .err_clr    (errClr)
  );

  operand_sel_pipe #(
    .WIDTH    (64),
    .N_IN     (8),
    .ERR_CNT_W(8)
  ) u_dut_stream (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (streamValid),
    .in_ready   (streamReady),
    .in_sel     (streamSel),
    .in_data    (streamData),
    .out_valid  (streamOutValid),
    .out_ready  (streamOutReady),
    .out_data   (streamOutData),
    .out_sel_err(streamOutSelErr),
    .err_count  (streamErrCount),
    .err_clr    (streamErrClr)
  );

  // Free-running clock; stimulus changes and sampling happen on the falling edge.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [64:0] observed,
                             input logic [64:0] expected);
    checkCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the 6-input instance for one clock, then return at the next falling edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] sel,
                               input logic ready, input logic clr);
    inValid  = valid;
    inSel    = sel;
    outReady = ready;
    errClr   = clr;
    @(negedge clk);
  endtask

  task automatic setCandidates(input logic [63:0] base);
    for (int k = 0; k < 6; k++) begin
      inData[k*64 +: 64] = base + 64'(k);
    end
  endtask

  // Directed sequence followed by a scoreboarded random run.
  initial begin
    checkCount     = 0;
    failCount      = 0;
    rst_n          = 1'b0;
    inValid        = 1'b0;
    inSel          = '0;
    inData         = '0;
    outReady       = 1'b1;
    errClr         = 1'b0;
    streamValid    = 1'b0;
    streamSel      = '0;
    streamData     = '0;
    streamOutReady = 1'b1;
    streamErrClr   = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] reset state");
    checkOutput("rst_out_valid", 65'(outValid), 65'(0));
    checkOutput("rst_out_data", 65'(outData), 65'(0));
    checkOutput("rst_sel_err", 65'(outSelErr), 65'(0));
    checkOutput("rst_err_count", 65'(errCount), 65'(0));
    checkOutput("rst_in_ready", 65'(inReady), 65'(1));
    rst_n = 1'b1;

    $display("[TB] streaming select on 8 inputs");
    for (int k = 0; k < 8; k++) begin
      streamData[k*64 +: 64] = 64'h1000 + 64'(k);
    end
    for (int i = 0; i < 8; i++) begin
      streamValid = 1'b1;
      streamSel   = 3'(i);
      @(negedge clk);
      checkOutput("stream_valid", 65'(streamOutValid), 65'(1));
      checkOutput("stream_beat", {streamOutData, streamOutSelErr},
                  {64'h1000 + 64'(i), 1'b0});
      checkOutput("stream_in_ready", 65'(streamReady), 65'(1));
    end
    streamValid = 1'b0;
    @(negedge clk);
    checkOutput("stream_drained", 65'(streamOutValid), 65'(0));

    $display("[TB] out-of-range selects on 6 inputs");
    setCandidates(64'hA8);
    applyStimulus(1'b1, 3'd2, 1'b1, 1'b0);
    checkOutput("good_beat", {outData, outSelErr}, {64'hAA, 1'b0});
    checkOutput("good_err_count", 65'(errCount), 65'(0));
    setCandidates(64'hDEAD_0000);
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
    checkOutput("bad7_beat", {outData, outSelErr}, {64'hAA, 1'b1});
    checkOutput("bad7_err_count", 65'(errCount), 65'(1));
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
    checkOutput("bad6_beat", {outData, outSelErr}, {64'hAA, 1'b1});
    checkOutput("bad6_err_count", 65'(errCount), 65'(2));
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput("oor_drained", 65'(outValid), 65'(0));

    $display("[TB] backpressure");
    setCandidates(64'hB0);
    applyStimulus(1'b1, 3'd0, 1'b0, 1'b0);
    checkOutput("bp_first_beat", {outValid, outData}, {1'b1, 64'hB0});
    checkOutput("bp_ready_after_first", 65'(inReady), 65'(1));
    applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
    checkOutput("bp_ready_after_second", 65'(inReady), 65'(0));
    checkOutput("bp_hold_1", {outValid, outData}, {1'b1, 64'hB0});
    applyStimulus(1'b1, 3'd3, 1'b0, 1'b0);
    checkOutput("bp_ready_held_low", 65'(inReady), 65'(0));
    checkOutput("bp_hold_2", {outValid, outData}, {1'b1, 64'hB0});
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
    checkOutput("bp_second_out", {outValid, outData}, {1'b1, 64'hB1});
    checkOutput("bp_ready_rises", 65'(inReady), 65'(1));
    applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
    checkOutput("bp_third_out", {outData, outSelErr}, {64'hB3, 1'b0});
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput("bp_drained", 65'(outValid), 65'(0));
    checkOutput("bp_err_count", 65'(errCount), 65'(2));

    $display("[TB] counter saturation and clear");
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    checkOutput("clr_idle", 65'(errCount), 65'(0));
    for (int b = 0; b < 5; b++) begin
      applyStimulus(1'b1, (b % 2 == 0) ? 3'd6 : 3'd7, 1'b1, 1'b0);
      checkOutput("sat_count", 65'(errCount), 65'((b + 1 > 3) ? 3 : b + 1));
      checkOutput("sat_beat", {outData, outSelErr}, {64'hB3, 1'b1});
    end
    applyStimulus(1'b1, 3'd7, 1'b1, 1'b1);
    checkOutput("clr_wins", 65'(errCount), 65'(0));
    checkOutput("clr_beat", {outValid, outData, outSelErr}, {1'b1, 64'hB3, 1'b1});
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);

    $display("[TB] reset mid-stream");
    setCandidates(64'hC0);
    applyStimulus(1'b1, 3'd4, 1'b0, 1'b0);
    applyStimulus(1'b1, 3'd7, 1'b0, 1'b0);
    checkOutput("full_in_ready", 65'(inReady), 65'(0));
    checkOutput("full_err_count", 65'(errCount), 65'(1));
    rst_n = 1'b0;
    applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);
    checkOutput("mid_rst_out_valid", 65'(outValid), 65'(0));
    checkOutput("mid_rst_out", {outData, outSelErr}, 65'(0));
    checkOutput("mid_rst_err_count", 65'(errCount), 65'(0));
    checkOutput("mid_rst_in_ready", 65'(inReady), 65'(1));
    rst_n = 1'b1;
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
    checkOutput("post_rst_no_emit", 65'(outValid), 65'(0));
    applyStimulus(1'b1, 3'd6, 1'b1, 1'b0);
    checkOutput("post_rst_bad_beat", {outValid, outData, outSelErr}, {1'b1, 64'h0, 1'b1});
    checkOutput("post_rst_err_count", 65'(errCount), 65'(1));
    applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
    errClr = 1'b0;

    $display("[TB] random valid/ready run");
    for (int k = 0; k < 6; k++) begin
      cand[k] = {$urandom, $urandom};
      inData[k*64 +: 64] = cand[k];
    end
    modelLast   = '0;
    modelErr    = '0;
    acceptCount = 0;
    cycles      = 0;
    prevStalled = 1'b0;
    prevPayload = '0;
    while (acceptCount < 10000 && cycles < 60000) begin
      inValid  = ($urandom_range(0, 3) != 0);
      inSel    = 3'($urandom_range(0, 7));
      outReady = ($urandom_range(0, 2) != 0);
      if (prevStalled) begin
        checkOutput("stall_valid", 65'(outValid), 65'(1));
        checkOutput("stall_hold", {outData, outSelErr}, prevPayload);
      end
      if (outValid && outReady) begin
        checkOutput("rand_beat_avail", 65'(expQ.size() != 0), 65'(1));
        if (expQ.size() != 0) begin
          checkOutput("rand_beat", {outData, outSelErr}, expQ.pop_front());
        end
      end
      if (inValid && inReady) begin
        if (inSel < 3'd6) begin
          expBeat   = {cand[inSel], 1'b0};
          modelLast = cand[inSel];
        end else begin
          expBeat = {modelLast, 1'b1};
          if (modelErr != 2'b11) modelErr = modelErr + 2'd1;
        end
        expQ.push_back(expBeat);
        acceptCount++;
      end
      prevStalled = outValid && !outReady;
      prevPayload = {outData, outSelErr};
      @(negedge clk);
      cycles++;
    end
    checkOutput("rand_accept_budget", 65'(acceptCount), 65'(10000));

    inValid  = 1'b0;
    outReady = 1'b1;
    for (int d = 0; d < 8; d++) begin
      if (outValid && expQ.size() != 0) begin
        checkOutput("drain_beat", {outData, outSelErr}, expQ.pop_front());
      end
      @(negedge clk);
    end
    checkOutput("drain_empty", 65'(expQ.size()), 65'(0));
    checkOutput("drain_out_valid", 65'(outValid), 65'(0));
    checkOutput("rand_err_count", 65'(errCount), 65'(modelErr));

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule

// File: doc/operand_sel_pipe.md
# operand_sel_pipe

Parametrised, registered N-way operand selector for the decode stage. It accepts a select code and N_IN candidate operands per beat over a valid/ready handshake. It delivers the chosen operand one cycle later through a two-entry skid buffer, so backpressure never drops or duplicates a beat. Out-of-range select codes are handled deterministically: they are flagged, counted and replaced by a held value.

## Interface
Parameters:
- WIDTH, 64, operand width in bits
- N_IN, 8, number of candidate operands (2..16)
- SEL_W, $clog2(N_IN), select width (derived, not overridden)
- ERR_CNT_W, 8, width of the saturating error counter

Ports:
- clk  in  1  rising-edge clock; the single clock
- rst_n  in  1  reset, synchronous, active-low
- in_valid  in  1  upstream beat present
- in_ready  out  1  block can accept a beat
- in_sel  in  SEL_W  select code
- in_data  in  N_IN*WIDTH  candidates, operand k at bits [k*WIDTH +: WIDTH]
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts
- out_data  out  WIDTH  selected operand
- out_sel_err  out  1  this beat's select was out of range
- err_count  out  ERR_CNT_W  saturating count of out-of-range beats accepted
- err_clr  in  1  synchronous clear of err_count

## Operation
- Accept occurs when in_valid && in_ready. Emit occurs when out_valid && out_ready.
- On accept with in_sel < N_IN:
  - the beat payload is {in_data[in_sel], err=0};
  - last_good is updated to that operand.
- On accept with in_sel >= N_IN (possible only when N_IN is not a power of two):
  - the beat payload is {last_good, err=1};
  - last_good is unchanged;
  - err_count increments unless it is at all-ones, where it saturates.
- err_clr wins over a simultaneous increment: err_count becomes 0.
- Skid buffer, built from a main register and a skid register:
  - main empty, or main emitting this cycle: the accepted beat loads main;
  - main full and not emitting: the accepted beat loads skid;
  - main emits while skid is full: skid moves to main and skid empties.
- in_ready = !skid_valid, driven straight from a register with no combinational path from out_ready.
- Beats leave in acceptance order. Nothing is dropped or duplicated.

## Timing
- Latency: an accept in cycle t gives out_valid in cycle t+1, provided main was empty or emitting in t.
- Throughput: 1 beat per cycle while out_ready stays high.
- Backpressure, out_ready low with main full:
  - one further beat is absorbed into skid;
  - in_ready falls in the next cycle.
- in_ready rises the cycle after skid drains.
- Simultaneous accept and emit with main full and skid empty: main takes the new beat and skid stays empty.
- Outputs are stable while out_valid && !out_ready.
- Reset, when rst_n is low at a clock edge:
  - out_valid=0, out_data=0, out_sel_err=0, err_count=0;
  - skid emptied, so in_ready=1 after that edge;
  - last_good=0.
- Reset mid-operation discards all buffered beats. No emit follows reset until a new accept.
- in_sel and in_data are only sampled on accept. Their value is ignored when in_valid is low.

## Structure
- Shared package decode_pkg holds:
  - default WIDTH = 64 and N_IN = 8;
  - the operand-select encoding constants used by the decoder (OPSEL_RS1, OPSEL_IMM, OPSEL_PC, …);
  - the payload typedef {data, err}.
- One sub-module: skid_buf, a generic two-entry valid/ready buffer parametrised on payload width. Selection, last_good and err_count stay in operand_sel_pipe.

## Test plan
1. Streaming select: N_IN=8, WIDTH=64, in_data[k]=64'h1000+k, out_ready=1, in_sel=0..7 on consecutive cycles → out_data 64'h1000..64'h1007 on cycles 1..8, out_sel_err=0, in_ready constantly 1.
2. Out-of-range: N_IN=6, accept sel=2 (data 64'hAA), then sel=7 → second beat has out_data=64'hAA, out_sel_err=1, err_count=1.
3. Backpressure: hold out_ready=0 and offer 3 beats → 2 accepted, in_ready=0 from the cycle after the second accept; release out_ready → beats emerge in order and the third is then accepted.
4. Saturation and clear: ERR_CNT_W=2, 5 out-of-range beats → err_count=3; err_clr together with a sixth bad beat → err_count=0.
5. Reset mid-stream: both buffer entries full, rst_n=0 for one edge → out_valid=0, in_ready=1, err_count=0, last_good=0; the next bad select outputs 0.
6. Randomised valid/ready toggling over 10k beats against a scoreboard → no loss, no duplication, order preserved, out_data stable while stalled.
